// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Purpose  : Machine-mode CSR file and trap controller for an RV32I Zicsr
//            pipeline. Sits beside writeback and drives its trap inputs.
// Revision : 1.0  initial release
// ============================================================================
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] memory_pc,
    input  logic [2:0]  memory_funct3,
    input  logic [11:0] csr_index,
    input  logic [4:0]  csr_rs1,
    input  logic [31:0] csr_rs1_data,
    input  logic        is_csr,
    input  logic        is_mret,
    input  logic        exc_instr_misaligned,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_ecall,
    input  logic        exc_load_misaligned,
    input  logic        exc_store_misaligned,
    input  logic [31:0] exc_tval,
    input  logic        irq_external,
    input  logic        irq_timer,
    input  logic        irq_software,
    output logic [31:0] csr_data,
    output logic        go_to_trap,
    output logic        return_from_trap,
    output logic [31:0] trap_addr,
    output logic [31:0] return_addr
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MIE       = 12'h304;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MTVAL     = 12'h343;
    localparam logic [11:0] c_MIP       = 12'h344;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;
    localparam logic [31:0] c_MIE_MASK  = 32'h0000_0888;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_rdata;
    logic [31:0] w_irq_pend;
    logic        w_exc_any;
    logic        w_trap_req;
    logic [31:0] w_cause;
    logic        w_cause_has_tval;
    logic [31:0] w_operand;
    logic [31:0] w_wdata;
    logic        w_csr_we;
    logic        w_retire;

    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
    assign w_mip     = {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};

    // Old value of the addressed CSR; unimplemented indices read zero
    always_comb begin
        w_rdata = 32'h0;
        case (csr_index)
            c_MSTATUS:   w_rdata = w_mstatus;
            c_MIE:       w_rdata = r_mie;
            c_MTVEC:     w_rdata = r_mtvec;
            c_MSCRATCH:  w_rdata = r_mscratch;
            c_MEPC:      w_rdata = r_mepc;
            c_MCAUSE:    w_rdata = r_mcause;
            c_MTVAL:     w_rdata = r_mtval;
            c_MIP:       w_rdata = w_mip;
            c_MCYCLE:    w_rdata = r_mcycle[31:0];
            c_MCYCLEH:   w_rdata = r_mcycle[63:32];
            c_MINSTRET:  w_rdata = r_minstret[31:0];
            c_MINSTRETH: w_rdata = r_minstret[63:32];
            c_MHARTID:   w_rdata = 32'h0;
            default:     w_rdata = 32'h0;
        endcase
    end

    assign w_irq_pend = w_mip & r_mie & {32{r_mstatus_mie}};
    assign w_exc_any  = exc_instr_misaligned | exc_illegal | exc_ebreak |
                        exc_ecall | exc_load_misaligned | exc_store_misaligned;
    assign w_trap_req = clk_en & ((|w_irq_pend) | w_exc_any);

    // Cause selection: any enabled interrupt beats every exception
    always_comb begin
        w_cause          = 32'h0;
        w_cause_has_tval = 1'b0;
        if (w_irq_pend[11])            w_cause = 32'h8000_000B;
        else if (w_irq_pend[3])        w_cause = 32'h8000_0003;
        else if (w_irq_pend[7])        w_cause = 32'h8000_0007;
        else if (exc_instr_misaligned) begin w_cause = 32'd0;  w_cause_has_tval = 1'b1; end
        else if (exc_illegal)          begin w_cause = 32'd2;  w_cause_has_tval = 1'b1; end
        else if (exc_ebreak)           w_cause = 32'd3;
        else if (exc_ecall)            w_cause = 32'd11;
        else if (exc_load_misaligned)  begin w_cause = 32'd4;  w_cause_has_tval = 1'b1; end
        else if (exc_store_misaligned) begin w_cause = 32'd6;  w_cause_has_tval = 1'b1; end
    end

    assign go_to_trap       = ~rst & w_trap_req;
    assign return_from_trap = ~rst & clk_en & is_mret & ~w_trap_req;
    assign trap_addr        = {r_mtvec[31:2], 2'b00};
    assign return_addr      = r_mepc;
    assign csr_data         = w_rdata;

    // Set/clear forms with a zero source field leave the CSR untouched
    assign w_operand = memory_funct3[2] ? {27'b0, csr_rs1} : csr_rs1_data;
    assign w_csr_we  = clk_en & is_csr & ~w_trap_req & (memory_funct3[1:0] != 2'b00) &
                       ((memory_funct3[1:0] == 2'b01) | (csr_rs1 != 5'd0));
    assign w_retire  = clk_en & ~w_trap_req;

    // Read-modify-write value for the addressed CSR
    always_comb begin
        w_wdata = w_operand;
        case (memory_funct3[1:0])
            2'b10:   w_wdata = w_rdata | w_operand;
            2'b11:   w_wdata = w_rdata & ~w_operand;
            default: w_wdata = w_operand;
        endcase
    end

    // CSR state: trap entry wins over mret, mret wins over a CSR write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'h0;
            r_mtvec        <= MTVEC_RESET & ~32'h3;
            r_mscratch     <= 32'h0;
            r_mepc         <= 32'h0;
            r_mcause       <= 32'h0;
            r_mtval        <= 32'h0;
        end else if (w_trap_req) begin
            r_mepc         <= memory_pc & ~32'h3;
            r_mcause       <= w_cause;
            r_mtval        <= w_cause_has_tval ? exc_tval : 32'h0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (clk_en & is_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_csr_we) begin
            case (csr_index)
                c_MSTATUS: begin
                    r_mstatus_mie  <= w_wdata[3];
                    r_mstatus_mpie <= w_wdata[7];
                end
                c_MIE:      r_mie      <= w_wdata & c_MIE_MASK;
                c_MTVEC:    r_mtvec    <= w_wdata & ~32'h3;
                c_MSCRATCH: r_mscratch <= w_wdata;
                c_MEPC:     r_mepc     <= w_wdata & ~32'h3;
                c_MCAUSE:   r_mcause   <= w_wdata;
                c_MTVAL:    r_mtval    <= w_wdata;
                default:    ;
            endcase
        end
    end

    // 64-bit counters; a CSR write to one half replaces that cycle's increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= 64'h0;
            r_minstret <= 64'h0;
        end else begin
            if (w_csr_we && csr_index == c_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], w_wdata};
            else if (w_csr_we && csr_index == c_MCYCLEH)
                r_mcycle <= {w_wdata, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_csr_we && csr_index == c_MINSTRET)
                r_minstret <= {r_minstret[63:32], w_wdata};
            else if (w_csr_we && csr_index == c_MINSTRETH)
                r_minstret <= {w_wdata, r_minstret[31:0]};
            else if (w_retire)
                r_minstret <= r_minstret + 64'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_unit
// Purpose  : Self-checking bench for csr_trap_unit: directed scenarios with
//            literal expectations, then randomized traffic against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [31:0] memory_pc;
    logic [2:0]  memory_funct3;
    logic [11:0] csr_index;
    logic [4:0]  csr_rs1;
    logic [31:0] csr_rs1_data;
    logic        is_csr, is_mret;
    logic        exc_instr_misaligned, exc_illegal, exc_ebreak, exc_ecall;
    logic        exc_load_misaligned, exc_store_misaligned;
    logic [31:0] exc_tval;
    logic        irq_external, irq_timer, irq_software;
    logic [31:0] csr_data;
    logic        go_to_trap, return_from_trap;
    logic [31:0] trap_addr, return_addr;

    int n_checks = 0;
    int n_fail   = 0;

    csr_trap_unit #(.MTVEC_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .memory_pc(memory_pc),
        .memory_funct3(memory_funct3), .csr_index(csr_index), .csr_rs1(csr_rs1),
        .csr_rs1_data(csr_rs1_data), .is_csr(is_csr), .is_mret(is_mret),
        .exc_instr_misaligned(exc_instr_misaligned), .exc_illegal(exc_illegal),
        .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
        .exc_load_misaligned(exc_load_misaligned), .exc_store_misaligned(exc_store_misaligned),
        .exc_tval(exc_tval), .irq_external(irq_external), .irq_timer(irq_timer),
        .irq_software(irq_software), .csr_data(csr_data), .go_to_trap(go_to_trap),
        .return_from_trap(return_from_trap), .trap_addr(trap_addr), .return_addr(return_addr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_mie, m_mpie;
    logic [31:0] m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
    logic [63:0] m_cyc, m_ret;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 0; m_scratch = 0;
        m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ret = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] idx);
        logic [31:0] v;
        v = 32'h0;
        case (idx)
            12'h300: begin v = 32'h1800; v[3] = m_mie; v[7] = m_mpie; end
            12'h304: v = m_ie;
            12'h305: v = m_tvec;
            12'h340: v = m_scratch;
            12'h341: v = m_epc;
            12'h342: v = m_cause;
            12'h343: v = m_tval;
            12'h344: begin v[11] = irq_external; v[7] = irq_timer; v[3] = irq_software; end
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ret[31:0];
            12'hB82: v = m_ret[63:32];
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Trap decision from the priority lists: interrupts by cause number, then exceptions
    task automatic model_trap(output bit take, output logic [31:0] cause, output bit with_tval);
        int          irq_order[3] = '{11, 3, 7};
        int          exc_code[6]  = '{0, 2, 3, 11, 4, 6};
        bit          exc_tv[6]    = '{1, 1, 0, 0, 1, 1};
        bit          exc_on[6];
        logic [31:0] lines;
        exc_on = '{exc_instr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
                   exc_load_misaligned, exc_store_misaligned};
        lines = model_read(12'h344);
        take = 0; cause = 0; with_tval = 0;
        if (clk_en && m_mie) begin
            foreach (irq_order[i])
                if (!take && m_ie[irq_order[i]] && lines[irq_order[i]]) begin
                    take = 1; cause = 32'h8000_0000 | 32'(irq_order[i]);
                end
        end
        if (clk_en) begin
            foreach (exc_code[i])
                if (!take && exc_on[i]) begin
                    take = 1; cause = 32'(exc_code[i]); with_tval = exc_tv[i];
                end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model, then advance the model one edge
    task automatic sample();
        bit          take, tv, we, ret;
        logic [31:0] cause, old, opnd, wd;
        logic [63:0] cyc_n, ret_n;
        @(negedge clk);
        if (rst) model_reset();
        model_trap(take, cause, tv);
        if (rst) take = 0;
        ret = !rst && clk_en && is_mret && !take;
        old = model_read(csr_index);
        chk("go_to_trap", {31'b0, go_to_trap}, {31'b0, take});
        chk("return_from_trap", {31'b0, return_from_trap}, {31'b0, ret});
        chk("trap_addr", trap_addr, m_tvec);
        chk("return_addr", return_addr, m_epc);
        chk("csr_data", csr_data, old);
        if (rst) return;

        opnd = memory_funct3[2] ? {27'b0, csr_rs1} : csr_rs1_data;
        case (memory_funct3[1:0])
            2'b01:   wd = opnd;
            2'b10:   wd = old | opnd;
            default: wd = old & ~opnd;
        endcase
        we = clk_en && is_csr && !take && memory_funct3[1:0] != 0 &&
             (memory_funct3[1:0] == 2'b01 || csr_rs1 != 0);
        cyc_n = m_cyc + 1;
        ret_n = m_ret + ((clk_en && !take) ? 64'd1 : 64'd0);
        if (take) begin
            m_epc = {memory_pc[31:2], 2'b00};
            m_cause = cause;
            m_tval = tv ? exc_tval : 32'h0;
            m_mpie = m_mie; m_mie = 0;
        end else if (clk_en && is_mret) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (we) begin
            case (csr_index)
                12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
                12'h304: m_ie = wd & 32'h888;
                12'h305: m_tvec = {wd[31:2], 2'b00};
                12'h340: m_scratch = wd;
                12'h341: m_epc = {wd[31:2], 2'b00};
                12'h342: m_cause = wd;
                12'h343: m_tval = wd;
                12'hB00: cyc_n = {m_cyc[63:32], wd};
                12'hB80: cyc_n = {wd, m_cyc[31:0]};
                12'hB02: ret_n = {m_ret[63:32], wd};
                12'hB82: ret_n = {wd, m_ret[31:0]};
                default: ;
            endcase
        end
        m_cyc = cyc_n;
        m_ret = ret_n;
    endtask

    task automatic edge_next();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        clk_en = 0; memory_pc = 0; memory_funct3 = 0; csr_index = 0; csr_rs1 = 0;
        csr_rs1_data = 0; is_csr = 0; is_mret = 0; exc_instr_misaligned = 0;
        exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0; exc_load_misaligned = 0;
        exc_store_misaligned = 0; exc_tval = 0;
    endtask

    task automatic csr_op(input logic [2:0] f3, input logic [11:0] idx,
                          input logic [4:0] rs1, input logic [31:0] data);
        idle();
        clk_en = 1; is_csr = 1; memory_funct3 = f3; csr_index = idx;
        csr_rs1 = rs1; csr_rs1_data = data; memory_pc = 32'h200;
    endtask

    // Read with csrrs rd, csr, x0 and pin the value to a literal
    task automatic read_lit(input string name, input logic [11:0] idx, input logic [31:0] exp);
        csr_op(3'b010, idx, 5'd0, 32'hFFFF_FFFF);
        sample();
        chk(name, csr_data, exp);
        edge_next();
    endtask

    logic [11:0] idx_tab[16] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hF14, 12'h301, 12'h7C0, 12'hB01};
    logic [2:0]  f3_tab[6]   = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        idle();
        irq_external = 0; irq_timer = 0; irq_software = 0;
        rst = 1;
        model_reset();
        edge_next();
        // ecall during reset must not trap
        clk_en = 1; exc_ecall = 1; memory_pc = 32'h40;
        sample();
        chk("reset_go_to_trap", {31'b0, go_to_trap}, 32'h0);
        edge_next();
        rst = 0;
        idle();

        read_lit("reset_mstatus", 12'h300, 32'h0000_1800);
        read_lit("reset_mtvec", 12'h305, 32'h0);

        // mscratch RW then RS with x0
        csr_op(3'b001, 12'h340, 5'd2, 32'hDEAD_BEEF);
        sample(); chk("mscratch_old", csr_data, 32'h0); edge_next();
        read_lit("mscratch_new", 12'h340, 32'hDEAD_BEEF);
        read_lit("mscratch_kept", 12'h340, 32'hDEAD_BEEF);

        // ecall trap through mtvec = 0x100
        csr_op(3'b001, 12'h305, 5'd1, 32'h0000_0100);
        sample(); edge_next();
        idle(); clk_en = 1; exc_ecall = 1; memory_pc = 32'h40;
        sample();
        chk("ecall_go", {31'b0, go_to_trap}, 32'h1);
        chk("ecall_trap_addr", trap_addr, 32'h100);
        edge_next();
        read_lit("ecall_mepc", 12'h341, 32'h40);
        read_lit("ecall_mcause", 12'h342, 32'd11);
        read_lit("ecall_mstatus", 12'h300, 32'h1800);

        // interrupt beats illegal; external beats timer
        csr_op(3'b001, 12'h304, 5'd1, 32'h888);
        sample(); edge_next();
        csr_op(3'b110, 12'h300, 5'd8, 32'h0);
        sample(); edge_next();
        idle(); clk_en = 1; exc_illegal = 1; exc_tval = 32'h1234_5678; memory_pc = 32'h80;
        irq_timer = 1; irq_external = 1;
        sample();
        chk("irq_go", {31'b0, go_to_trap}, 32'h1);
        edge_next();
        irq_timer = 0; irq_external = 0;
        read_lit("irq_mcause", 12'h342, 32'h8000_000B);
        read_lit("irq_mepc", 12'h341, 32'h80);
        read_lit("irq_mtval", 12'h343, 32'h0);
        read_lit("irq_mstatus", 12'h300, 32'h1880);

        // mret back
        idle(); clk_en = 1; is_mret = 1;
        sample();
        chk("mret_ret", {31'b0, return_from_trap}, 32'h1);
        chk("mret_addr", return_addr, 32'h80);
        edge_next();
        read_lit("mret_mstatus", 12'h300, 32'h1888);

        // mcycle wrap
        csr_op(3'b001, 12'hB80, 5'd1, 32'hFFFF_FFFF); sample(); edge_next();
        csr_op(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF); sample(); edge_next();
        read_lit("mcycle_max", 12'hB00, 32'hFFFF_FFFF);
        read_lit("mcycle_wrap", 12'hB00, 32'h0);
        read_lit("mcycleh_wrap", 12'hB80, 32'h0);

        // minstret write beats its own increment
        csr_op(3'b001, 12'hB02, 5'd1, 32'd5); sample(); edge_next();
        read_lit("minstret_wr", 12'hB02, 32'd5);

        // reset asserted while an ecall sits in writeback
        idle(); clk_en = 1; exc_ecall = 1; memory_pc = 32'h44;
        rst = 1;
        sample();
        chk("rst_ecall_go", {31'b0, go_to_trap}, 32'h0);
        edge_next();
        rst = 0;
        read_lit("rst_mepc", 12'h341, 32'h0);
        read_lit("rst_mcause", 12'h342, 32'h0);

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            clk_en = ($urandom_range(0, 3) != 0);
            memory_pc = $urandom;
            exc_tval = $urandom;
            irq_external = ($urandom_range(0, 5) == 0);
            irq_timer    = ($urandom_range(0, 5) == 0);
            irq_software = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0: is_mret = 1;
                1: case ($urandom_range(0, 5))
                       0: exc_instr_misaligned = 1;
                       1: exc_illegal = 1;
                       2: exc_ebreak = 1;
                       3: exc_ecall = 1;
                       4: exc_load_misaligned = 1;
                       default: exc_store_misaligned = 1;
                   endcase
                2: begin exc_load_misaligned = 1; exc_ecall = ($urandom_range(0, 1) == 1); end
                default: is_csr = 1;
            endcase
            memory_funct3 = f3_tab[$urandom_range(0, 5)];
            csr_index = idx_tab[$urandom_range(0, 15)];
            csr_rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            csr_rs1_data = $urandom;
            sample();
            edge_next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and trap controller for the RV32I Zicsr pipeline, sitting beside the writeback stage. It takes the retiring instruction's CSR access, exception flags and interrupt lines, and drives the writeback stage's trap inputs: `go_to_trap`, `return_from_trap`, `trap_addr`, `return_addr` and `csr_data`. It holds all machine CSR state, including 64-bit cycle and retired-instruction counters, and commits updates on the clock edge that ends the instruction's writeback cycle.

## Interface
- `MTVEC_RESET`, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.
- Clock and reset are one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `clk_en`  in  1  a valid instruction is in writeback this cycle (same signal that feeds writeback)
- `memory_pc`  in  32  PC of that instruction
- `memory_funct3`  in  3  CSR operation (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- `csr_index`  in  12  CSR address
- `csr_rs1`  in  5  rs1 field, used as zimm for the immediate forms
- `csr_rs1_data`  in  32  rs1 value
- `is_csr`, `is_mret`  in  1  decoded SYSTEM subtype
- `exc_instr_misaligned`, `exc_illegal`, `exc_ebreak`, `exc_ecall`, `exc_load_misaligned`, `exc_store_misaligned`  in  1 each  synchronous exception flags
- `exc_tval`  in  32  faulting address or instruction word
- `irq_external`, `irq_timer`, `irq_software`  in  1 each  level interrupt lines
- `csr_data`  out  32  old value of the addressed CSR (combinational)
- `go_to_trap`, `return_from_trap`  out  1  combinational trap controls
- `trap_addr`  out  32  mtvec with bits [1:0] = 0
- `return_addr`  out  32  mepc

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7] writable; MPP[12:11] reads 2'b11.
  - mie 0x304: MSIE[3], MTIE[7], MEIE[11].
  - mip 0x344: read-only mirror of the irq lines.
  - mtvec 0x305: direct mode only.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced 0.
  - mcause 0x342.
  - mtval 0x343.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - mhartid 0xF14: reads 0.
- Any other index reads 0, and writes to it are dropped.
- CSR write operand: if funct3[2] is set, the operand is {27'b0, csr_rs1}; otherwise it is `csr_rs1_data`.
- CSR write value: RW writes the operand; RS writes old | operand; RC writes old & ~operand.
- RS/RC/RSI/RCI with `csr_rs1` == 0 perform no write. RW/RWI always write.
- Interrupt pending: mstatus.MIE & mie[k] & mip[k]. Priority is MEI (cause 11) > MSI (3) > MTI (7). mcause[31] = 1 for interrupts.
- Exception priority: instr_misaligned (0) > illegal (2) > ebreak (3) > ecall (11) > load_misaligned (4) > store_misaligned (6).
- A pending interrupt beats any exception.
- `go_to_trap` = clk_en & (interrupt pending | any exception flag).
- `return_from_trap` = clk_en & is_mret & !go_to_trap.
- Trap entry, at the edge ending the cycle:
  - mepc <= memory_pc.
  - mcause <= selected cause.
  - mtval <= exc_tval for misaligned or illegal causes, else 0.
  - MPIE <= MIE, MIE <= 0.
  - The instruction's own CSR write is suppressed.
- mret, at the edge: MIE <= MPIE, MPIE <= 1.
- Counters:
  - mcycle increments every cycle out of reset.
  - minstret increments when clk_en & !go_to_trap; mret and CSR instructions count.
  - Both are 64-bit and wrap from 2^64-1 to 0.
  - A CSR write to either half takes precedence over that counter's increment that cycle; the other half keeps its old value.

## Timing
- Reset values:
  - mstatus reads 0x0000_1800.
  - mie, mscratch, mepc, mcause, mtval and both counters are 0.
  - mtvec = MTVEC_RESET & ~3.
- While `rst` is high, `go_to_trap` = 0 and `return_from_trap` = 0.
- All outputs are combinational from the current state and current inputs, with zero latency. The writeback stage consumes them in the same cycle.
- State updates land at the next rising edge. A CSR read in cycle N returns the pre-write value; cycle N+1 sees the new value.
- When clk_en = 0 there are no CSR writes, no traps and no minstret increment. mcycle still counts.
- mret while MIE = 0 and an interrupt is pending: mret retires first. The interrupt is taken on the next valid instruction, once MIE = 1.
- Writing mstatus.MIE = 1 takes effect for the next instruction, not the writing one.
- If reset asserts mid-operation, all state returns to its reset value immediately; no partial trap commit is allowed.

## Test plan
- `csrrw x1, mscratch, x2` with x2 = 0xDEAD_BEEF, then `csrrs x3, mscratch, x0` -> first `csr_data` = 0; second `csr_data` = 0xDEAD_BEEF and mscratch is unchanged.
- mtvec = 0x100, ecall at PC 0x40 -> go_to_trap = 1 and trap_addr = 0x100 that cycle. Next cycle: mepc = 0x40, mcause = 11, MIE = 0, MPIE = old MIE.
- MIE = 1, mie = 0x888, irq_timer and irq_external both high with illegal asserted at PC 0x80 -> mcause = 0x8000_000B and mepc = 0x80. The illegal exception is not recorded.
- After the trap above, mret -> return_from_trap = 1 and return_addr = 0x80. Next cycle: MIE = 1, MPIE = 1.
- mcycle = 0xFFFF_FFFF_FFFF_FFFF -> the next cycle reads 0. A write of 5 to minstret on a retiring instruction -> the next cycle reads 5, not 6.
- Assert `rst` in the cycle an ecall is in writeback -> go_to_trap = 0, and mepc/mcause remain 0 after reset.
